uart_tx_arbiter: RTL and testbench

Shares the single `Uart` transmitter between N byte-stream requesters such as the text-memory streamer, a debug monitor and a status reporter. Grants are round-robin and message-atomic: once granted, a requester keeps the UART until it sends a byte flagged LAST, or until it stalls for longer than TIMEOUT cycles. The block sits between the requesters and the `Uart` IN/OE/RDY port inside `SoC`.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
// Holds the FSM encoding, the byte width and the index-width helper.
package uart_arb_pkg;

  localparam int UART_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // clog2 with a floor of 1 so a vector of width 0 never appears
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set request
// at or above ptr, wrapping modulo N.
// Ports: req (N requests), ptr (start index) -> idx (winner), any (winner valid).
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int SW = IW + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] off;
  logic [SW-1:0] sum;

  always_comb begin
    // rot[k] is the request k positions above ptr
    rot = N'({req, req} >> ptr);
    off = '0;
    any = 1'b0;
    // descending scan so the nearest set bit wins
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = SW'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one UART.
// Ports: CLK/RST, REQ_VALID/REQ_DATA/REQ_LAST in, REQ_READY out,
// UART_IN/UART_OE out, UART_RDY in, GRANT/BUSY status out.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 1024,
  localparam int IW      = idx_w(N),
  localparam int CW      = idx_w(TIMEOUT)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N-1:0]        REQ_VALID,
  input  logic [UART_W*N-1:0] REQ_DATA,
  input  logic [N-1:0]        REQ_LAST,
  output logic [N-1:0]        REQ_READY,
  output logic [UART_W-1:0]   UART_IN,
  output logic                UART_OE,
  input  logic                UART_RDY,
  output logic [IW-1:0]       GRANT,
  output logic                BUSY
);

  arb_state_t        state;
  logic [IW-1:0]     ptr;
  logic [CW-1:0]     idle_cnt;
  logic [UART_W-1:0] hold;
  logic              hold_v;

  logic [IW-1:0]     pick;
  logic              pick_any;
  logic [UART_W-1:0] req_byte [N];
  logic              cur_valid;
  logic              cur_last;
  logic              take;
  logic              drain;
  logic              stalled;
  logic              expired;
  logic [IW-1:0]     nxt;

  rr_pick #(.N(N)) u_pick (
    .req (REQ_VALID),
    .ptr (ptr),
    .idx (pick),
    .any (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_byte[i] = REQ_DATA[UART_W*i +: UART_W];
    end
  end

  assign cur_valid = REQ_VALID[GRANT];
  assign cur_last  = REQ_LAST[GRANT];
  assign take      = (state == ST_SEND) && !hold_v && cur_valid;
  assign drain     = hold_v && UART_RDY;
  assign stalled   = (state == ST_SEND) && !hold_v && !cur_valid;
  assign expired   = stalled && (idle_cnt == CW'(TIMEOUT - 1));
  assign nxt       = (GRANT == IW'(N - 1)) ? '0 : GRANT + IW'(1);

  // ready only depends on registers: no input-to-output path
  always_comb begin
    REQ_READY = '0;
    if (state == ST_SEND && !hold_v) begin
      REQ_READY[GRANT] = 1'b1;
    end
  end

  assign UART_OE = hold_v;
  assign UART_IN = hold;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      GRANT    <= '0;
      BUSY     <= 1'b0;
      hold     <= '0;
      hold_v   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            GRANT    <= pick;
            BUSY     <= 1'b1;
            idle_cnt <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // take and drain are exclusive: hold is never refilled
          // in the cycle it empties
          if (take) begin
            hold     <= req_byte[GRANT];
            hold_v   <= 1'b1;
            idle_cnt <= '0;
            if (cur_last) begin
              state <= ST_DRAIN;
            end
          end else if (drain) begin
            hold_v   <= 1'b0;
            idle_cnt <= '0;
          end else if (expired) begin
            ptr   <= nxt;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end else if (stalled) begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain) begin
            hold_v <= 1'b0;
            ptr    <= nxt;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and
// randomized message traffic against a message-level model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ_VALID;
  logic [31:0] REQ_DATA;
  logic [3:0]  REQ_LAST;
  logic [3:0]  REQ_READY;
  logic [7:0]  UART_IN;
  logic        UART_OE;
  logic        UART_RDY;
  logic [1:0]  GRANT;
  logic        BUSY;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .UART_IN   (UART_IN),
    .UART_OE   (UART_OE),
    .UART_RDY  (UART_RDY),
    .GRANT     (GRANT),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_bad;
  int cyc;

  // per-requester message store: {last, byte}
  logic [8:0]  qd [4][64];
  int          qh [4];
  int          qt [4];
  int          stall [4];
  bit          auto_on;
  bit          stall_en;
  int          rdy_mode;
  // expected UART stream: {owner, last, byte}
  logic [10:0] expq [$];

  typedef struct packed {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_oe;
    logic [7:0]  e_in;
    logic        e_busy;
    logic [1:0]  e_grant;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [3:0]  hs;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic [10:0] e;
    logic        lb;
    if (auto_on) begin
      v = '0;
      d = '0;
      l = '0;
      for (int i = 0; i < N; i++) begin
        if (qh[i] < qt[i] && stall[i] == 0) begin
          v[i] = 1'b1;
          d[8*i +: 8] = qd[i][qh[i]][7:0];
          l[i] = qd[i][qh[i]][8];
        end
      end
      REQ_VALID = v;
      REQ_DATA  = d;
      REQ_LAST  = l;
      case (rdy_mode)
        0:       UART_RDY = 1'b1;
        1:       UART_RDY = 1'($urandom_range(0, 1));
        default: UART_RDY = (cyc % 10 == 0);
      endcase
    end
    @(negedge CLK);
    hs = REQ_VALID & REQ_READY;
    if (auto_on) begin
      chk("ready_mask", 32'(REQ_READY & ~(4'b0001 << GRANT)), 0);
      if (UART_OE && UART_RDY) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %02h want none", UART_IN);
        end else begin
          e = expq.pop_front();
          chk("uart_byte", 32'(UART_IN), 32'(e[7:0]));
          chk("uart_owner", 32'(GRANT), 32'(e[10:9]));
          chk("busy_at_hs", 32'(BUSY), 1);
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (auto_on) begin
      for (int i = 0; i < N; i++) begin
        if (stall[i] > 0) stall[i]--;
        if (hs[i]) begin
          lb = qd[i][qh[i]][8];
          qh[i]++;
          stall[i] = (!lb && stall_en) ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    auto_on   = 1'b0;
    RST       = 1'b1;
    REQ_VALID = '0;
    REQ_DATA  = '0;
    REQ_LAST  = '0;
    UART_RDY  = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    for (int i = 0; i < N; i++) begin
      qh[i]    = 0;
      qt[i]    = 0;
      stall[i] = 0;
    end
    expq.delete();
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input logic lst);
    qd[r][qt[r]] = {lst, b};
    qt[r]++;
  endtask

  task automatic add_msg(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      add_byte(r, 8'($urandom), b == len - 1);
    end
  endtask

  // whole messages, round-robin over requesters with pending work, ptr=0
  task automatic build_exp();
    int h [4];
    int p;
    int j;
    bit found;
    logic [8:0] r;
    for (int i = 0; i < N; i++) h[i] = qh[i];
    p = 0;
    for (int guard = 0; guard < 64; guard++) begin
      found = 1'b0;
      j = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && h[(p + k) % N] < qt[(p + k) % N]) begin
          found = 1'b1;
          j = (p + k) % N;
        end
      end
      if (!found) break;
      do begin
        r = qd[j][h[j]];
        h[j]++;
        expq.push_back({2'(j), r});
      end while (!r[8]);
      p = (j + 1) % N;
    end
  endtask

  task automatic run_until_empty(input int budget);
    int c;
    c = 0;
    while (expq.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    chk("stream_done", 32'(expq.size()), 0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    auto_on  = 1'b0;
    stall_en = 1'b0;
    rdy_mode = 0;

    // reset state
    do_reset();
    chk("rst_ready", 32'(REQ_READY), 0);
    chk("rst_oe", 32'(UART_OE), 0);
    chk("rst_in", 32'(UART_IN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_grant", 32'(GRANT), 0);

    // cycle vectors: one-byte msg from 3, two-byte msg from 1, wrap pick
    tv[0] = '{4'b1000, 32'hA500_0000, 4'b1000, 1'b0, 4'b1000, 1'b0, 8'h00, 1'b1, 2'd3};
    tv[1] = '{4'b1000, 32'hA500_0000, 4'b1000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd3};
    tv[2] = '{4'b0000, 32'h0,         4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 2'd3};
    tv[3] = '{4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 2'd3};
    tv[4] = '{4'b0010, 32'h0000_3C00, 4'b0000, 1'b0, 4'b0010, 1'b0, 8'hA5, 1'b1, 2'd1};
    tv[5] = '{4'b0010, 32'h0000_3C00, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h3C, 1'b1, 2'd1};
    tv[6] = '{4'b0010, 32'h0000_7E00, 4'b0010, 1'b1, 4'b0010, 1'b0, 8'h3C, 1'b1, 2'd1};
    tv[7] = '{4'b0010, 32'h0000_7E00, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h7E, 1'b1, 2'd1};
    tv[8] = '{4'b0000, 32'h0,         4'b0000, 1'b1, 4'b0000, 1'b0, 8'h7E, 1'b0, 2'd1};
    tv[9] = '{4'b0011, 32'h0000_2211, 4'b0011, 1'b0, 4'b0001, 1'b0, 8'h7E, 1'b1, 2'd0};
    for (int k = 0; k < 10; k++) begin
      REQ_VALID = tv[k].v;
      REQ_DATA  = tv[k].d;
      REQ_LAST  = tv[k].l;
      UART_RDY  = tv[k].rdy;
      tick();
      chk($sformatf("tv%0d_ready", k), 32'(REQ_READY), 32'(tv[k].e_ready));
      chk($sformatf("tv%0d_oe", k), 32'(UART_OE), 32'(tv[k].e_oe));
      chk($sformatf("tv%0d_in", k), 32'(UART_IN), 32'(tv[k].e_in));
      chk($sformatf("tv%0d_busy", k), 32'(BUSY), 32'(tv[k].e_busy));
      chk($sformatf("tv%0d_grant", k), 32'(GRANT), 32'(tv[k].e_grant));
    end

    // "Hi" from requester 2, UART ready one cycle in ten
    do_reset();
    auto_on  = 1'b1;
    stall_en = 1'b0;
    rdy_mode = 2;
    add_byte(2, 8'h48, 1'b0);
    add_byte(2, 8'h69, 1'b1);
    build_exp();
    run_until_empty(200);
    chk("hi_busy_fall", 32'(BUSY), 0);

    // round robin among 0, 1, 3
    do_reset();
    auto_on  = 1'b1;
    rdy_mode = 0;
    for (int m = 0; m < 2; m++) begin
      add_msg(0, 1);
      add_msg(1, 1);
      add_msg(3, 1);
    end
    build_exp();
    run_until_empty(200);

    // atomicity: requester 0 shows up mid-message of requester 1
    do_reset();
    auto_on  = 1'b1;
    rdy_mode = 1;
    add_byte(1, 8'hA1, 1'b0);
    add_byte(1, 8'hA2, 1'b0);
    add_byte(1, 8'hA3, 1'b0);
    add_byte(1, 8'hA4, 1'b1);
    expq.push_back({2'd1, 1'b0, 8'hA1});
    expq.push_back({2'd1, 1'b0, 8'hA2});
    expq.push_back({2'd1, 1'b0, 8'hA3});
    expq.push_back({2'd1, 1'b1, 8'hA4});
    n = 0;
    while (qh[1] == 0 && n < 200) begin
      tick();
      n++;
    end
    chk("atom_first_taken", 32'(qh[1]), 1);
    add_byte(0, 8'hB0, 1'b1);
    expq.push_back({2'd0, 1'b1, 8'hB0});
    run_until_empty(500);

    // timeout after a non-last byte
    do_reset();
    REQ_VALID = 4'b0011;
    REQ_DATA  = 32'h0000_775A;
    REQ_LAST  = 4'b0010;
    UART_RDY  = 1'b1;
    tick();
    chk("tmo_grant0", 32'(GRANT), 0);
    chk("tmo_ready0", 32'(REQ_READY), 32'h1);
    tick();
    chk("tmo_oe", 32'(UART_OE), 1);
    chk("tmo_in", 32'(UART_IN), 32'h5A);
    REQ_VALID = 4'b0010;
    tick();
    chk("tmo_drained", 32'(UART_OE), 0);
    n = 0;
    while (BUSY && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), TMO);
    tick();
    chk("tmo_next_grant", 32'(GRANT), 1);
    chk("tmo_next_ready", 32'(REQ_READY), 32'h2);

    // backpressure: byte held while UART is not ready
    do_reset();
    REQ_VALID = 4'b1000;
    REQ_DATA  = 32'hC300_0000;
    REQ_LAST  = 4'b0000;
    UART_RDY  = 1'b0;
    tick();
    tick();
    REQ_VALID = 4'b0000;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("bp_oe", 32'(UART_OE), 1);
      chk("bp_in", 32'(UART_IN), 32'hC3);
      chk("bp_ready", 32'(REQ_READY), 0);
      chk("bp_busy", 32'(BUSY), 1);
    end
    UART_RDY = 1'b1;
    tick();
    chk("bp_release_oe", 32'(UART_OE), 0);
    chk("bp_release_busy", 32'(BUSY), 1);

    // reset during DRAIN with ptr already advanced
    do_reset();
    REQ_VALID = 4'b0010;
    REQ_DATA  = 32'h0000_1100;
    REQ_LAST  = 4'b0010;
    UART_RDY  = 1'b1;
    tick();
    tick();
    REQ_VALID = 4'b0000;
    tick();
    REQ_VALID = 4'b0100;
    REQ_DATA  = 32'h0099_0000;
    REQ_LAST  = 4'b0100;
    UART_RDY  = 1'b0;
    tick();
    chk("rd_grant2", 32'(GRANT), 2);
    tick();
    chk("rd_held_oe", 32'(UART_OE), 1);
    chk("rd_held_in", 32'(UART_IN), 32'h99);
    RST       = 1'b1;
    REQ_VALID = 4'b0110;
    REQ_DATA  = 32'h0099_2200;
    REQ_LAST  = 4'b0110;
    tick();
    RST = 1'b0;
    chk("rd_ready", 32'(REQ_READY), 0);
    chk("rd_oe", 32'(UART_OE), 0);
    chk("rd_in", 32'(UART_IN), 0);
    chk("rd_busy", 32'(BUSY), 0);
    chk("rd_grant", 32'(GRANT), 0);
    tick();
    chk("rd_regrant", 32'(GRANT), 1);
    chk("rd_regrant_ready", 32'(REQ_READY), 32'h2);

    // randomized message traffic with short mid-message stalls
    for (int r = 0; r < 3; r++) begin
      do_reset();
      auto_on  = 1'b1;
      stall_en = 1'b1;
      rdy_mode = r;
      for (int i = 0; i < N; i++) begin
        n = int'($urandom_range(0, 3));
        for (int m = 0; m < n; m++) begin
          add_msg(i, int'($urandom_range(1, 4)));
        end
      end
      build_exp();
      run_until_empty(4000);
      chk("rand_idle", 32'(BUSY), 0);
    end

    auto_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
